max_pool_2x2: RTL and testbench
===============================

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, pixel width in bits (unsigned pixels).
REQ-002 SHALL have parameter IN_WIDTH, default 538, number of valid pixels per input row (width of the convolution output).
REQ-003 SHALL have parameter IN_HEIGHT, default 358, number of valid input rows per frame.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port inputPixel  input  WORD_SIZE  convolution output pixel, sampled only when inValid=1.
REQ-007 SHALL have port inValid  input  1  qualifies inputPixel; one pixel is accepted per cycle with inValid=1.
REQ-008 SHALL have port outputPixel  output  WORD_SIZE  maximum of one 2x2 input block.
REQ-009 SHALL have port outValid  output  1  one-cycle strobe qualifying outputPixel.
REQ-010 SHALL have port frameDone  output  1  one-cycle strobe marking acceptance of the last pixel of a frame.

Function
REQ-011 SHALL track accepted pixels with a column counter col (0..IN_WIDTH-1) and a row counter row (0..IN_HEIGHT-1), both advancing only on inValid=1.
REQ-012 SHALL wrap col from IN_WIDTH-1 to 0 and increment row on that wrap.
REQ-013 SHALL wrap row from IN_HEIGHT-1 to 0 at the last pixel of a frame, so the next accepted pixel is (0,0) of a new frame.
REQ-014 SHALL hold counters, line buffer and outputPixel unchanged on cycles with inValid=0, and SHALL drive outValid=0 on the following cycle.
REQ-015 SHALL register the pixel accepted at an even col as prevPixel.
REQ-016 SHALL, on an even row at an odd col, compute hmax = max(prevPixel, inputPixel) and write it to lineBuf[col>>1].
REQ-016a SHALL size lineBuf at IN_WIDTH/2 entries of WORD_SIZE bits.
REQ-017 SHALL, on an odd row at an odd col, set outputPixel = max(lineBuf[col>>1], prevPixel, inputPixel) and outValid=1 on the next cycle (latency 1 clock from acceptance of the block's bottom-right pixel).
REQ-018 SHALL use unsigned comparison for all max operations; on equal values either operand may be chosen, since the result is identical.
REQ-019 SHALL discard the last column without output when IN_WIDTH is odd; col still counts it.
REQ-020 SHALL discard the last row without output when IN_HEIGHT is odd; row still counts it.
REQ-021 SHALL produce exactly (IN_WIDTH/2)*(IN_HEIGHT/2) outValid strobes per frame, in raster order.
REQ-022 SHALL drive frameDone=1 on the cycle after acceptance of pixel (IN_HEIGHT-1, IN_WIDTH-1); this coincides with the final outValid when both dimensions are even.
REQ-023 SHALL tolerate arbitrary inValid gaps, including gaps between the two pixels of a pair and between rows, with results identical to gap-free input.
REQ-024 SHALL not require lineBuf to be initialised; each entry is written on an even row before it is read on the next odd row.
REQ-024a SHALL keep synthesis of lineBuf memory-inferable: one write port, one read port, no reset on lineBuf.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set col=0, row=0, prevPixel=0, outputPixel=0, outValid=0 and frameDone=0, with rst dominating inValid.
REQ-026 SHALL treat a reset asserted mid-frame as abandoning that frame; the first pixel accepted after rst deasserts is (0,0), and no output is generated from pre-reset data.

Verification
REQ-027 SHALL pass this scenario: IN_WIDTH=4, IN_HEIGHT=2, continuous inValid, rows {1,5,2,3},{4,0,9,7} -> outValid strobes carrying 5 then 9; frameDone coincides with 9.
REQ-028 SHALL pass this scenario: same stimulus with inValid=0 for 3 cycles between every pixel -> same outputs 5, 9; outValid is never high two cycles in a row.
REQ-029 SHALL pass this scenario: IN_WIDTH=5, IN_HEIGHT=3, all pixels = 255 except 0 in col 4 and row 2 -> exactly 2 outputs, both 255; frameDone after pixel 15.
REQ-030 SHALL pass this scenario: two back-to-back frames, IN_WIDTH=4, IN_HEIGHT=2, second frame all 0x10 -> outputs 5, 9, 0x10, 0x10; row/col wrap with no extra strobe.
REQ-031 SHALL pass this scenario: rst pulsed after 5 pixels of a frame, then a full frame sent -> no output from the first 5 pixels; outputs match the fresh frame only; outputPixel=0 during reset.
REQ-032 SHALL pass this scenario: the default-parameter frame with random pixels, compared against a software 2x2/stride-2 max-pool model -> 269*179 outputs, all matching.

Source files
------------

// File: rtl/max_pool_2x2.sv
// 2x2 / stride-2 max pooling over a raster pixel stream.
// Each top-row pair max is kept in a half-width line buffer until the matching bottom pair arrives.
`timescale 1ns/1ps
module max_pool_2x2 #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned IN_WIDTH  = 538,
    parameter int unsigned IN_HEIGHT = 358
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic                 inValid,
    output logic [WORD_SIZE-1:0] outputPixel,
    output logic                 outValid,
    output logic                 frameDone
);

    localparam int unsigned COL_W  = $clog2(IN_WIDTH) + 1;
    localparam int unsigned ROW_W  = $clog2(IN_HEIGHT) + 1;
    localparam int unsigned HALF_W = IN_WIDTH / 2;
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [WORD_SIZE-1:0] prev_q, prev_d;
    logic [WORD_SIZE-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [WORD_SIZE-1:0] line_buf [HALF_W];
    logic [IDX_W-1:0]     buf_idx;
    logic                 buf_we;
    logic [WORD_SIZE-1:0] buf_rd;
    logic [WORD_SIZE-1:0] hmax;
    logic [WORD_SIZE-1:0] vmax;
    logic                 last_col;
    logic                 last_row;

    assign buf_idx  = IDX_W'(col_q >> 1);
    assign last_col = (col_q == COL_W'(IN_WIDTH - 1));
    assign last_row = (row_q == ROW_W'(IN_HEIGHT - 1));
    assign buf_rd   = line_buf[buf_idx];
    assign hmax     = (inputPixel > prev_q) ? inputPixel : prev_q;
    assign vmax     = (buf_rd > hmax) ? buf_rd : hmax;

    // Even col latches the left pixel; odd col stores (even row) or emits (odd row) the block max.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        prev_d       = prev_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        if (inValid && !rst) begin
            if (!col_q[0]) begin
                prev_d = inputPixel;
            end else if (!row_q[0]) begin
                buf_we = 1'b1;
            end else begin
                out_d       = vmax;
                out_valid_d = 1'b1;
            end
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            prev_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            prev_q       <= prev_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Single write / single read port, no reset, so the buffer can map onto a RAM.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_idx] <= hmax;
        end
    end

    assign outputPixel = out_q;
    assign outValid    = out_valid_q;
    assign frameDone   = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: three geometries (4x2, 5x3, 538x5) checked against
// a direct 2x2 block-max model computed from whole frames.
`timescale 1ns/1ps
module tb_max_pool_2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] pix  [3];
    logic       vld  [3];
    logic [7:0] opix [3];
    logic       oval [3];
    logic       fdone[3];
    bit         ov_exp[3];
    bit         fd_exp[3];
    bit         in_rst = 1'b0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic [7:0] frm[$];

    int errors = 0;
    int checks = 0;

    max_pool_2x2 #(.WORD_SIZE(8), .IN_WIDTH(4), .IN_HEIGHT(2)) dut_a (
        .clk(clk), .rst(rst), .inputPixel(pix[0]), .inValid(vld[0]),
        .outputPixel(opix[0]), .outValid(oval[0]), .frameDone(fdone[0]));

    max_pool_2x2 #(.WORD_SIZE(8), .IN_WIDTH(5), .IN_HEIGHT(3)) dut_b (
        .clk(clk), .rst(rst), .inputPixel(pix[1]), .inValid(vld[1]),
        .outputPixel(opix[1]), .outValid(oval[1]), .frameDone(fdone[1]));

    max_pool_2x2 #(.WORD_SIZE(8), .IN_WIDTH(538), .IN_HEIGHT(5)) dut_c (
        .clk(clk), .rst(rst), .inputPixel(pix[2]), .inValid(vld[2]),
        .outputPixel(opix[2]), .outValid(oval[2]), .frameDone(fdone[2]));

    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [7:0] v);
        case (k)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop_exp(input int k, output logic [7:0] v);
        case (k)
            0:       v = exp_q0.pop_front();
            1:       v = exp_q1.pop_front();
            default: v = exp_q2.pop_front();
        endcase
    endtask

    // Monitor: compares every strobe against the scoreboard, independent of the driver.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (in_rst) begin
                check("rst_outputPixel", k, 32'(opix[k]), 32'd0);
                check("rst_outValid", k, 32'(oval[k]), 32'd0);
                check("rst_frameDone", k, 32'(fdone[k]), 32'd0);
            end else begin
                if (oval[k] === 1'b1 || ov_exp[k])
                    check("outValid_timing", k, 32'(oval[k]), 32'(ov_exp[k]));
                if (oval[k] === 1'b1) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d t=%0t: got %0h expected none", k, $time, opix[k]);
                    end else begin
                        logic [7:0] e;
                        pop_exp(k, e);
                        check("outputPixel", k, 32'(opix[k]), 32'(e));
                    end
                end
                if (fdone[k] === 1'b1 || fd_exp[k])
                    check("frameDone", k, 32'(fdone[k]), 32'(fd_exp[k]));
            end
        end
    end

    // One clock of stimulus; ov/fd are what the DUT must show after this cycle's edge.
    task automatic cyc(input int k, input bit v, input logic [7:0] p, input bit ov, input bit fd);
        vld[k] = v;
        pix[k] = p;
        @(posedge clk);
        #1;
        vld[k]    = 1'b0;
        ov_exp[k] = ov;
        fd_exp[k] = fd;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) cyc(k, 1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) vld[k] = 1'b0;
        @(posedge clk);
        #1;
        in_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ov_exp[k] = 1'b0;
            fd_exp[k] = 1'b0;
        end
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        rst    = 1'b0;
        in_rst = 1'b0;
    endtask

    // Reference: pool the whole frame up front, then stream it with random gaps.
    task automatic send_frame(input int k, input int w, input int h, input int gmin, input int gmax);
        for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++)
                push_exp(k, max2(max2(frm[2*r*w + 2*c], frm[2*r*w + 2*c + 1]),
                                 max2(frm[(2*r+1)*w + 2*c], frm[(2*r+1)*w + 2*c + 1])));
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                idle(k, int'($urandom_range(gmax, gmin)));
                cyc(k, 1'b1, frm[r*w + c], (r % 2 == 1) && (c % 2 == 1), (r == h - 1) && (c == w - 1));
            end
    endtask

    task automatic fill_rand(input int n);
        frm.delete();
        repeat (n) frm.push_back(($urandom_range(0, 3) == 0) ? 8'd200 : 8'($urandom));
    endtask

    task automatic load_basic();
        logic [7:0] s[8] = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7};
        frm.delete();
        foreach (s[i]) frm.push_back(s[i]);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            pix[k] = 8'd0;
        end
        do_reset(3);

        // 4x2 basic frame, continuous then with 3-cycle gaps
        load_basic();
        send_frame(0, 4, 2, 0, 0);
        idle(0, 3);
        load_basic();
        send_frame(0, 4, 2, 3, 3);
        idle(0, 4);

        // Back-to-back frames, second all 0x10
        load_basic();
        send_frame(0, 4, 2, 0, 0);
        frm.delete();
        repeat (8) frm.push_back(8'h10);
        send_frame(0, 4, 2, 0, 0);
        idle(0, 3);

        // Mid-frame reset after 5 bright pixels; only the fresh frame may produce output
        for (int i = 0; i < 5; i++) cyc(0, 1'b1, 8'hFF, 1'b0, 1'b0);
        do_reset(2);
        fill_rand(8);
        send_frame(0, 4, 2, 0, 2);
        idle(0, 3);
        repeat (4) begin
            fill_rand(8);
            send_frame(0, 4, 2, 0, 1);
        end
        idle(0, 3);

        // 5x3: odd width and height, trailing column/row of zeros discarded
        frm.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                frm.push_back((c == 4 || r == 2) ? 8'd0 : 8'd255);
        send_frame(1, 5, 3, 0, 0);
        idle(1, 3);
        repeat (3) begin
            fill_rand(15);
            send_frame(1, 5, 3, 0, 2);
        end
        idle(1, 3);

        // Full default row width, odd height
        repeat (2) begin
            fill_rand(538 * 5);
            send_frame(2, 538, 5, 0, 1);
        end
        idle(2, 3);

        for (int k = 0; k < 3; k++) check("scoreboard_drained", k, 32'(qsize(k)), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
